// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
// Groups the scan-code input strobe and the decoded key-state/event outputs
// of ps2_key_decoder into one bundle.
//   recievedData    : scan-code byte from the PS2 controller
//   recievedNewData : one-cycle strobe, recievedData valid
//   keyState        : held-key vector, 1 = key down
//   eventValid      : one-cycle pulse on a press or release
//   eventIndex      : key index of the last event
//   eventIsRelease  : 1 = release, 0 = press
// Modports: master drives scan codes (PS2 side / testbench), slave is the decoder.
interface ps2_key_decoder_if #(
    parameter int NUM_KEYS = 29
);
    logic [7:0]          recievedData;
    logic                recievedNewData;
    logic [NUM_KEYS-1:0] keyState;
    logic                eventValid;
    logic [4:0]          eventIndex;
    logic                eventIsRelease;

    modport master (
        output recievedData, recievedNewData,
        input  keyState, eventValid, eventIndex, eventIsRelease
    );

    modport slave (
        input  recievedData, recievedNewData,
        output keyState, eventValid, eventIndex, eventIsRelease
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns a stream of PS2 set-2 scan-code bytes into a held-key vector and a
// press/release event pulse for 29 keys (digits row, top letter row, space).
// Ports:
//   CLOCK_50 : clock, all logic on posedge
//   resetn   : synchronous reset, active HIGH despite its name
//   bus      : ps2_key_decoder_if.slave (scan codes in, key state/events out)
// Parameters:
//   NUM_KEYS       : width of keyState (at least 29)
//   PREFIX_TIMEOUT : clocks a pending F0/E0 prefix survives without a new byte
// Build option:
//   TYPEMATIC_FILTER_EN : when defined, a make code for a key already held
//                         produces no event (auto-repeat suppressed).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no prefix pending; make codes become presses
// BREAK     | F0 seen; next mapped code is a release
// EXT       | E0 seen; extended key, byte is discarded
// EXT_BREAK | E0 F0 seen; extended release, byte is discarded
module ps2_key_decoder #(
    parameter int NUM_KEYS       = 29,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    ps2_key_decoder_if.slave bus
);
    localparam int TIMER_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    state_t state, nextState;

    logic [TIMER_W-1:0]  timerCnt;
    logic                timeoutHit;
    logic                codeHit;
    logic [4:0]          codeIdx;
    logic                doPress;
    logic                doRelease;
    logic [NUM_KEYS-1:0] keyStateReg;
    logic                eventValidReg;
    logic [4:0]          eventIndexReg;
    logic                eventIsReleaseReg;

    wire newByte  = bus.recievedNewData;
    wire isBreak  = (bus.recievedData == 8'hF0);
    wire isExtend = (bus.recievedData == 8'hE0);

    always_comb begin
        codeHit = 1'b1;
        codeIdx = 5'd0;
        case (bus.recievedData)
            8'h0E: codeIdx = 5'd0;
            8'h16: codeIdx = 5'd1;
            8'h1E: codeIdx = 5'd2;
            8'h26: codeIdx = 5'd3;
            8'h25: codeIdx = 5'd4;
            8'h2E: codeIdx = 5'd5;
            8'h36: codeIdx = 5'd6;
            8'h3D: codeIdx = 5'd7;
            8'h3E: codeIdx = 5'd8;
            8'h46: codeIdx = 5'd9;
            8'h45: codeIdx = 5'd10;
            8'h4E: codeIdx = 5'd11;
            8'h55: codeIdx = 5'd12;
            8'h66: codeIdx = 5'd13;
            8'h0D: codeIdx = 5'd14;
            8'h15: codeIdx = 5'd15;
            8'h1D: codeIdx = 5'd16;
            8'h24: codeIdx = 5'd17;
            8'h2D: codeIdx = 5'd18;
            8'h2C: codeIdx = 5'd19;
            8'h35: codeIdx = 5'd20;
            8'h3C: codeIdx = 5'd21;
            8'h43: codeIdx = 5'd22;
            8'h44: codeIdx = 5'd23;
            8'h4D: codeIdx = 5'd24;
            8'h54: codeIdx = 5'd25;
            8'h5B: codeIdx = 5'd26;
            8'h5D: codeIdx = 5'd27;
            8'h29: codeIdx = 5'd28;
            default: codeHit = 1'b0;
        endcase
    end

    // A strobe in the timeout cycle is handled in the prefix state, so the
    // timeout only steers the FSM when no byte arrives.
    assign timeoutHit = (state != IDLE) && (timerCnt == TIMER_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            state    <= IDLE;
            timerCnt <= '0;
        end else begin
            state <= nextState;
            if (newByte || state == IDLE || timeoutHit)
                timerCnt <= '0;
            else
                timerCnt <= timerCnt + TIMER_W'(1);
        end
    end

    always_comb begin
        nextState = state;
        if (newByte) begin
            unique case (state)
                IDLE:      nextState = isBreak ? BREAK : (isExtend ? EXT : IDLE);
                BREAK:     nextState = isBreak ? BREAK : (isExtend ? EXT_BREAK : IDLE);
                EXT:       nextState = isBreak ? EXT_BREAK : IDLE;
                EXT_BREAK: nextState = IDLE;
                default:   nextState = IDLE;
            endcase
        end else if (timeoutHit) begin
            nextState = IDLE;
        end
    end

    always_comb begin
        doPress   = 1'b0;
        doRelease = 1'b0;
        if (newByte && codeHit) begin
            if (state == IDLE) begin
`ifdef TYPEMATIC_FILTER_EN
                doPress = !keyStateReg[codeIdx];
`else
                doPress = 1'b1;
`endif
            end else if (state == BREAK) begin
                // Releasing a key that is not held is silently dropped.
                doRelease = keyStateReg[codeIdx];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            keyStateReg       <= '0;
            eventValidReg     <= 1'b0;
            eventIndexReg     <= 5'd0;
            eventIsReleaseReg <= 1'b0;
        end else begin
            eventValidReg <= doPress || doRelease;
            if (doPress || doRelease) begin
                eventIndexReg     <= codeIdx;
                eventIsReleaseReg <= doRelease;
            end
            if (doPress)
                keyStateReg[codeIdx] <= 1'b1;
            else if (doRelease)
                keyStateReg[codeIdx] <= 1'b0;
        end
    end

    assign bus.keyState       = keyStateReg;
    assign bus.eventValid     = eventValidReg;
    assign bus.eventIndex     = eventIndexReg;
    assign bus.eventIsRelease = eventIsReleaseReg;
endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;
    localparam int NK = 29;
    localparam int PT = 16;

    logic CLOCK_50 = 1'b0;
    logic resetn;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_decoder_if #(.NUM_KEYS(NK)) bus ();

    ps2_key_decoder #(.NUM_KEYS(NK), .PREFIX_TIMEOUT(PT)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus.slave)
    );

    logic [7:0] codeTable [NK] = '{
        8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29
    };

    int checkCount = 0;
    int errorCount = 0;

    // reference model: key set plus "which prefixes are pending"
    logic [NK-1:0] mKeys;
    bit            mValid;
    logic [4:0]    mIdx;
    bit            mRel;
    bit            sawF0, sawE0;
    int            cycleNo = 0;
    int            lastStrobe = 0;
    int            evCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cycleNo, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [7:0] code);
        for (int k = 0; k < NK; k++)
            if (codeTable[k] == code) return k;
        return -1;
    endfunction

    task automatic modelEdge(input bit rst, input bit stb, input logic [7:0] data);
        int idx;
        mValid = 1'b0;
        if (rst) begin
            mKeys = '0; mIdx = 5'd0; mRel = 1'b0; sawF0 = 1'b0; sawE0 = 1'b0;
            return;
        end
        if (!stb) return;
        // a prefix left alone for more than PT clocks has been abandoned
        if (cycleNo - lastStrobe > PT) begin
            sawF0 = 1'b0; sawE0 = 1'b0;
        end
        lastStrobe = cycleNo;
        idx = lookup(data);
        if (sawE0) begin
            if (!sawF0 && data == 8'hF0) sawF0 = 1'b1;
            else begin sawF0 = 1'b0; sawE0 = 1'b0; end
        end else if (sawF0) begin
            if (data == 8'hE0) sawE0 = 1'b1;
            else if (data != 8'hF0) begin
                sawF0 = 1'b0;
                if (idx >= 0 && mKeys[idx]) begin
                    mKeys[idx] = 1'b0;
                    mValid = 1'b1; mIdx = 5'(idx); mRel = 1'b1;
                end
            end
        end else begin
            if (data == 8'hF0) sawF0 = 1'b1;
            else if (data == 8'hE0) sawE0 = 1'b1;
            else if (idx >= 0) begin
`ifdef TYPEMATIC_FILTER_EN
                if (!mKeys[idx]) begin
                    mValid = 1'b1; mIdx = 5'(idx); mRel = 1'b0;
                end
`else
                mValid = 1'b1; mIdx = 5'(idx); mRel = 1'b0;
`endif
                mKeys[idx] = 1'b1;
            end
        end
    endtask

    task automatic stepCycle(input bit rst, input bit stb, input logic [7:0] data);
        resetn              = rst;
        bus.recievedNewData = stb;
        bus.recievedData    = data;
        @(posedge CLOCK_50);
        cycleNo++;
        modelEdge(rst, stb, data);
        #1;
        checkVal("keyState", 32'(bus.keyState), 32'(mKeys));
        checkVal("eventValid", 32'(bus.eventValid), 32'(mValid));
        checkVal("eventIndex", 32'(bus.eventIndex), 32'(mIdx));
        checkVal("eventIsRelease", 32'(bus.eventIsRelease), 32'(mRel));
        if (bus.eventValid === 1'b1) evCount++;
    endtask

    task automatic sendByte(input logic [7:0] data);
        stepCycle(1'b0, 1'b1, data);
        stepCycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) stepCycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int gap;
        int pick;
        logic [7:0] b;
        resetn = 1'b1;
        bus.recievedNewData = 1'b0;
        bus.recievedData = 8'h00;

        stepCycle(1'b1, 1'b0, 8'h00);
        stepCycle(1'b1, 1'b0, 8'h00);

        // single press, one-cycle latency
        stepCycle(1'b0, 1'b1, 8'h15);
        checkVal("press15_valid", 32'(bus.eventValid), 32'd1);
        checkVal("press15_index", 32'(bus.eventIndex), 32'd15);
        stepCycle(1'b0, 1'b0, 8'h00);
        checkVal("press15_pulse_drop", 32'(bus.eventValid), 32'd0);

        // hold 15 and 1D, release 15
        sendByte(8'h1D);
        sendByte(8'hF0);
        stepCycle(1'b0, 1'b1, 8'h15);
        checkVal("rel15_isRelease", 32'(bus.eventIsRelease), 32'd1);
        checkVal("rel15_key16_held", 32'(bus.keyState[16]), 32'd1);
        idleCycles(2);

        // extended keys leave keyState alone
        sendByte(8'hE0); sendByte(8'h75);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        sendByte(8'h0E);

        // prefix timeout then spacebar: a press
        stepCycle(1'b0, 1'b1, 8'hF0);
        idleCycles(PT);
        stepCycle(1'b0, 1'b1, 8'h29);
        checkVal("timeout_space_press", 32'(bus.eventIsRelease), 32'd0);
        idleCycles(1);

        // strobe exactly in the timeout cycle stays in BREAK: release space
        stepCycle(1'b0, 1'b1, 8'hF0);
        idleCycles(PT - 1);
        stepCycle(1'b0, 1'b1, 8'h29);
        checkVal("timeout_edge_release", 32'(bus.eventIsRelease), 32'd1);
        idleCycles(1);

        // auto-repeat of key 1
        evCount = 0;
        sendByte(8'h16); sendByte(8'h16); sendByte(8'h16);
`ifdef TYPEMATIC_FILTER_EN
        checkVal("typematic_events", 32'(evCount), 32'd1);
`else
        checkVal("typematic_events", 32'(evCount), 32'd3);
`endif
        checkVal("typematic_key1", 32'(bus.keyState[1]), 32'd1);

        // release of an unheld key, then strobe with reset
        sendByte(8'hF0); sendByte(8'h45);
        stepCycle(1'b1, 1'b1, 8'h16);
        checkVal("reset_strobe_keys", 32'(bus.keyState), 32'd0);
        // reset mid-prefix discards F0
        sendByte(8'hF0);
        stepCycle(1'b1, 1'b0, 8'h00);
        sendByte(8'h16);

        // randomized traffic
        for (int t = 0; t < 500; t++) begin
            gap = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(PT - 2, PT + 2);
            idleCycles(gap);
            pick = $urandom_range(0, 9);
            if (pick < 5) b = codeTable[$urandom_range(0, NK - 1)];
            else if (pick < 7) b = 8'hF0;
            else if (pick < 8) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            stepCycle(($urandom_range(0, 199) == 0), 1'b1, b);
        end
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 29, meaning the width of the key-state vector.
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 1000000, meaning the number of clocks a pending F0/E0 prefix is held before it is abandoned.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock, one clock domain; all logic on posedge.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port recievedData, input, 8 bits: scan-code byte from the PS2 controller.
REQ-006 SHALL have port recievedNewData, input, 1 bit: one-cycle strobe marking recievedData valid.
REQ-007 SHALL have port keyState, output, NUM_KEYS bits: held-key vector, 1 = key down.
REQ-008 SHALL have port eventValid, output, 1 bit: one-cycle pulse on a key press or release.
REQ-009 SHALL have port eventIndex, output, 5 bits: key index of the event.
REQ-010 SHALL have port eventIsRelease, output, 1 bit: 1 = release, 0 = press.

Function
REQ-011 SHALL map make codes to indices 0..28 in this order: 0E,16,1E,26,25,2E,36,3D,3E,46,45,4E,55,66,0D,15,1D,24,2D,2C,35,3C,43,44,4D,54,5B,5D,29; spacebar (29h) = 28.
REQ-012 SHALL run FSM states IDLE, BREAK, EXT, EXT_BREAK; bytes are examined only in cycles with recievedNewData=1.
REQ-013 IDLE: F0 -> BREAK; E0 -> EXT; mapped code -> press; unmapped code -> no action, stay IDLE.
REQ-014 BREAK: mapped code -> release, then IDLE; F0 -> stay BREAK; E0 -> EXT_BREAK; unmapped code -> IDLE, no event.
REQ-015 EXT: F0 -> EXT_BREAK; any other byte is discarded -> IDLE. EXT_BREAK: any byte is discarded -> IDLE. Extended keys SHALL never alter keyState.
REQ-016 Press SHALL set keyState[idx]; release SHALL clear keyState[idx]; no other bit changes.
REQ-017 keyState, eventValid, eventIndex and eventIsRelease SHALL update in the cycle after the strobe (1-clock latency); eventValid SHALL be high for exactly one cycle.
REQ-018 A release of a key whose keyState bit is already 0 SHALL produce no event.
REQ-019 A timeout counter SHALL count clocks while in BREAK/EXT/EXT_BREAK, clear on every strobe and in IDLE; on reaching PREFIX_TIMEOUT-1 the FSM SHALL return to IDLE with no event.
REQ-020 A strobe arriving in the same cycle as the timeout SHALL be processed in the prefix state (the strobe wins).
REQ-021 eventIndex and eventIsRelease SHALL hold their last values while eventValid=0.

Reset
REQ-022 With resetn=1 at a clock edge: keyState=0, eventValid=0, eventIndex=0, eventIsRelease=0, FSM=IDLE, timeout counter=0.
REQ-023 A strobe coinciding with reset SHALL be ignored; reset mid-prefix SHALL discard the prefix.

Configuration
REQ-024 Macro TYPEMATIC_FILTER_EN: when defined, a make code for a key already held SHALL produce no event (keyState unchanged); when undefined, every make code SHALL pulse eventValid with eventIsRelease=0, including auto-repeats.

Verification
REQ-025 Reset, then bytes 15 -> keyState[15]=1, eventValid pulse, eventIndex=15, eventIsRelease=0, one cycle after the strobe.
REQ-026 Hold 15 and 1D, then F0,15 -> keyState[15]=0, keyState[16] stays 1, release event at index 15.
REQ-027 Bytes E0,75 then E0,F0,75 -> keyState unchanged, no events, FSM back in IDLE.
REQ-028 Byte F0 then silence for PREFIX_TIMEOUT clocks, then 29 -> a press at index 28 (not a release).
REQ-029 Byte 16 three times: with TYPEMATIC_FILTER_EN, 1 event; without it, 3 events; keyState[1]=1 in both cases.
REQ-030 F0,45 with key 0 not held -> no event; byte 16 together with resetn=1 -> keyState stays 0.
